// File: rtl/uart_tx_fifo_feeder_pkg.sv
// Shared types for the UART transmit FIFO feeder.
//   TX_FIFO_state_type : hand-off FSM states (idle, load byte, request, wait busy)
//   TXF_DEFAULT_DEPTH_LOG2 / TXF_MIN_DEPTH_LOG2 / TXF_MAX_DEPTH_LOG2 : depth parameter range
package uart_tx_fifo_feeder_pkg;

  localparam int unsigned TXF_DEFAULT_DEPTH_LOG2 = 4;
  localparam int unsigned TXF_MIN_DEPTH_LOG2     = 2;
  localparam int unsigned TXF_MAX_DEPTH_LOG2     = 8;

  typedef enum logic [1:0] {
    S_TXF_IDLE = 2'd0,
    S_TXF_LOAD = 2'd1,
    S_TXF_REQ  = 2'd2,
    S_TXF_BUSY = 2'd3
  } TX_FIFO_state_type;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Byte storage for the UART transmit FIFO: 2**DEPTH_LOG2 x 8 RAM,
// synchronous write port, asynchronous (combinational) read port.
//   i_clk   : system clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational from i_raddr)
module uart_tx_fifo_mem #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [7:0]            i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [7:0]            o_rdata
);

  logic [7:0] r_mem [2**DEPTH_LOG2];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO feeding the UART transmit controller over the
// Start/TX_data/Empty handshake. System logic can burst up to 2**DEPTH_LOG2
// bytes at full clock rate; bytes leave one at a time, in order.
//   Clock      : system clock
//   Resetn     : asynchronous active-low reset
//   Write_en   : push Write_data (ignored when Full)
//   Write_data : byte to enqueue
//   Full       : FIFO holds 2**DEPTH_LOG2 bytes
//   Fill_level : bytes stored, excluding the byte already handed to TX
//   Overflow   : sticky, set by a write attempt while Full
//   Clear_ovf  : clears Overflow (a simultaneous overflowing write wins)
//   TX_start   : start request to the transmit controller (registered)
//   TX_data    : byte offered to the controller, stable while TX_start=1
//   TX_empty   : controller idle / stop bit in progress
module uart_tx_fifo_feeder
  import uart_tx_fifo_feeder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = TXF_DEFAULT_DEPTH_LOG2
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                Write_en,
  input  logic [7:0]          Write_data,
  output logic                Full,
  output logic [DEPTH_LOG2:0] Fill_level,
  output logic                Overflow,
  input  logic                Clear_ovf,
  output logic                TX_start,
  output logic [7:0]          TX_data,
  input  logic                TX_empty
);

  localparam logic [DEPTH_LOG2:0] PTR_ONE = (DEPTH_LOG2+1)'(1);

  TX_FIFO_state_type r_state, w_state_nxt;

  logic [DEPTH_LOG2:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0] w_fill;
  logic                w_full, w_push, w_load, w_have_data;
  logic                r_overflow, r_tx_start, w_tx_start_nxt;
  logic [7:0]          r_tx_data, w_rd_data;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign w_fill      = r_wr_ptr - r_rd_ptr;
  assign w_full      = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                       (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  assign w_push      = Write_en & ~w_full;
  assign w_have_data = (w_fill != '0);

  uart_tx_fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .i_clk   (Clock),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr[DEPTH_LOG2-1:0]),
    .i_wdata (Write_data),
    .i_raddr (r_rd_ptr[DEPTH_LOG2-1:0]),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      // LOAD is only entered with data present, so the pop never underflows.
      if (w_load) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (Write_en && w_full) r_overflow <= 1'b1;
      else if (Clear_ovf)     r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state    <= S_TXF_IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tx_start <= w_tx_start_nxt;
      if (w_load) r_tx_data <= w_rd_data;
    end
  end

  // TX_empty may still be 1 in REQ while the controller waits for a baud tick;
  // only its fall shows the byte has been latched.
  always_comb begin
    w_state_nxt    = r_state;
    w_tx_start_nxt = r_tx_start;
    w_load         = 1'b0;
    case (r_state)
      S_TXF_IDLE: if (w_have_data) w_state_nxt = S_TXF_LOAD;
      S_TXF_LOAD: begin
        w_load         = 1'b1;
        w_tx_start_nxt = 1'b1;
        w_state_nxt    = S_TXF_REQ;
      end
      S_TXF_REQ: if (!TX_empty) begin
        w_tx_start_nxt = 1'b0;
        w_state_nxt    = S_TXF_BUSY;
      end
      S_TXF_BUSY: if (TX_empty) w_state_nxt = w_have_data ? S_TXF_LOAD : S_TXF_IDLE;
      default: begin
        w_state_nxt    = S_TXF_IDLE;
        w_tx_start_nxt = 1'b0;
      end
    endcase
  end

  assign Full       = w_full;
  assign Fill_level = w_fill;
  assign Overflow   = r_overflow;
  assign TX_start   = r_tx_start;
  assign TX_data    = r_tx_data;

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
module tb_uart_tx_fifo_feeder;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Write_en;
  logic [7:0] Write_data;
  logic       Full;
  logic [4:0] Fill_level;
  logic       Overflow;
  logic       Clear_ovf;
  logic       TX_start;
  logic [7:0] TX_data;
  logic       TX_empty;

  // TX_empty comes either from the behavioural controller or from the main sequence.
  logic ctrl_en;
  logic ctrl_empty;
  logic man_empty;
  assign TX_empty = ctrl_en ? ctrl_empty : man_empty;

  uart_tx_fifo_feeder #(.DEPTH_LOG2(4)) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Write_en   (Write_en),
    .Write_data (Write_data),
    .Full       (Full),
    .Fill_level (Fill_level),
    .Overflow   (Overflow),
    .Clear_ovf  (Clear_ovf),
    .TX_start   (TX_start),
    .TX_data    (TX_data),
    .TX_empty   (TX_empty)
  );

  always #5 Clock = ~Clock;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [7:0] exp_q [$];
  logic [7:0] got_mem [64];
  int unsigned got_cnt = 0;
  int unsigned got_rd  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural transmit controller: latches the offered byte, drops Empty
  // for a frame time, then raises it again.
  initial begin
    ctrl_empty = 1'b1;
    forever begin
      @(negedge Clock);
      if (ctrl_en && TX_start && ctrl_empty) begin
        got_mem[got_cnt[5:0]] = TX_data;
        got_cnt++;
        ctrl_empty = 1'b0;
        repeat (6) @(negedge Clock);
        ctrl_empty = 1'b1;
      end
    end
  end

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic wr(input logic [7:0] d, input bit accept);
    Write_en   = 1'b1;
    Write_data = d;
    if (accept) exp_q.push_back(d);
    tick();
    Write_en = 1'b0;
  endtask

  task automatic drain(input int unsigned n);
    int unsigned budget = 0;
    logic [7:0] e;
    while (got_cnt < got_rd + n && budget < 2000) begin
      tick();
      budget++;
    end
    chk("drain_done", 32'(got_cnt >= got_rd + n), 32'd1);
    for (int unsigned i = 0; i < n; i++) begin
      if (got_rd < got_cnt && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tx_byte_order", 32'(got_mem[got_rd[5:0]]), 32'(e));
        got_rd++;
      end
    end
    repeat (10) tick();
  endtask

  task automatic wait_start();
    int unsigned budget = 0;
    while (!TX_start && budget < 50) begin
      tick();
      budget++;
    end
    chk("wait_tx_start", 32'(TX_start), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned bad;
    logic [7:0] e;
    Resetn = 1'b0; Write_en = 1'b0; Write_data = '0; Clear_ovf = 1'b0;
    ctrl_en = 1'b0; man_empty = 1'b1;
    repeat (3) tick();
    chk("rst_full", 32'(Full), 0);
    chk("rst_fill", 32'(Fill_level), 0);
    chk("rst_ovf", 32'(Overflow), 0);
    chk("rst_start", 32'(TX_start), 0);
    chk("rst_data", 32'(TX_data), 0);
    Resetn = 1'b1;
    repeat (2) tick();

    // Single byte into an idle block: TX_start after three edges.
    wr(8'hA5, 1);
    chk("lat1_start", 32'(TX_start), 0);
    chk("lat1_fill", 32'(Fill_level), 1);
    tick();
    chk("lat2_start", 32'(TX_start), 0);
    tick();
    chk("lat3_start", 32'(TX_start), 1);
    chk("lat3_data", 32'(TX_data), 32'h00A5);
    chk("lat3_fill", 32'(Fill_level), 0);

    // REQ held for 100 clocks with no acceptance.
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (TX_start !== 1'b1 || TX_data !== 8'hA5) bad++;
    end
    chk("req_hold_stable", bad, 0);
    ctrl_en = 1'b1;
    drain(1);
    chk("a5_fill_after", 32'(Fill_level), 0);

    // Fill to Full while the FSM parks in REQ, then exercise Overflow.
    ctrl_en = 1'b0;
    wr(8'h80, 1);
    repeat (4) tick();
    for (int i = 0; i < 16; i++) wr(8'(i), 1);
    chk("full_set", 32'(Full), 1);
    chk("full_fill", 32'(Fill_level), 16);
    chk("full_ovf_clear", 32'(Overflow), 0);
    wr(8'hFF, 0);
    chk("ovf_set", 32'(Overflow), 1);
    chk("ovf_fill", 32'(Fill_level), 16);
    repeat (5) tick();
    chk("ovf_sticky", 32'(Overflow), 1);
    Clear_ovf = 1'b1; tick(); Clear_ovf = 1'b0;
    chk("ovf_cleared", 32'(Overflow), 0);
    Clear_ovf = 1'b1; wr(8'hEE, 0); Clear_ovf = 1'b0;
    chk("ovf_write_wins", 32'(Overflow), 1);
    Clear_ovf = 1'b1; tick(); Clear_ovf = 1'b0;
    chk("ovf_cleared2", 32'(Overflow), 0);
    ctrl_en = 1'b1;
    drain(17);
    chk("burst_fill_after", 32'(Fill_level), 0);
    chk("burst_full_after", 32'(Full), 0);

    // Write in the same cycle as a LOAD with five bytes waiting.
    ctrl_en = 1'b0;
    wr(8'h11, 1);
    wait_start();
    e = exp_q.pop_front();
    chk("manual_byte", 32'(TX_data), 32'(e));
    man_empty = 1'b0;
    tick();
    chk("busy_start_low", 32'(TX_start), 0);
    for (int i = 0; i < 5; i++) wr(8'h21 + 8'(i), 1);
    chk("pre_load_fill", 32'(Fill_level), 5);
    man_empty = 1'b1;
    tick();
    wr(8'h26, 1);
    chk("load_wr_fill", 32'(Fill_level), 5);
    chk("load_wr_start", 32'(TX_start), 1);
    ctrl_en = 1'b1;
    drain(6);
    chk("wrap_fill_after", 32'(Fill_level), 0);

    // Asynchronous reset while a byte is in BUSY with more queued.
    ctrl_en = 1'b0;
    wr(8'h41, 1); wr(8'h42, 1); wr(8'h43, 1);
    wait_start();
    man_empty = 1'b0;
    tick();
    chk("busy_fill", 32'(Fill_level), 2);
    #2 Resetn = 1'b0;
    #1;
    chk("arst_full", 32'(Full), 0);
    chk("arst_fill", 32'(Fill_level), 0);
    chk("arst_ovf", 32'(Overflow), 0);
    chk("arst_start", 32'(TX_start), 0);
    chk("arst_data", 32'(TX_data), 0);
    exp_q.delete();
    tick();
    Resetn = 1'b1;
    man_empty = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (TX_start !== 1'b0 || Fill_level !== 5'd0) bad++;
    end
    chk("post_rst_quiet", bad, 0);
    wr(8'h3C, 1);
    ctrl_en = 1'b1;
    drain(1);
    chk("final_fill", 32'(Fill_level), 0);
    chk("final_q_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
